alu_shift_seq: RTL

ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

---
 rtl/alu_shift_seq.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alu_shift_seq.sv
// alu_shift_seq: multi-cycle 16-bit shifter for the ALU shift op codes (16..31).
// One bit step per cycle; the result and {ZF,NF,CF,OF} are registered on entry to
// DONE and held until the next completed operation.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   start, opsel      request (sampled in IDLE only) and op code ([4] shift op,
//                     [3]=0 forces count 1, [2:0] shift kind)
//   srcA, srcB        operand and shift count (srcB[3:0])
//   Cflag, Oflag      incoming carry / overflow
//   busy, ready       operation in progress / one-cycle result-valid pulse
//   res, flag_next    shifted result and {ZF,NF,CF,OF}
module alu_shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [4:0]  opsel,
    input  logic [15:0] srcA,
    input  logic [15:0] srcB,
    input  logic        Cflag,
    input  logic        Oflag,
    output logic        busy,
    output logic        ready,
    output logic [15:0] res,
    output logic [3:0]  flag_next
);

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned KW = 3;

    localparam logic [KW-1:0] K_RSL = 3'd0;
    localparam logic [KW-1:0] K_LSL = 3'd1;
    localparam logic [KW-1:0] K_RSA = 3'd2;
    localparam logic [KW-1:0] K_LSA = 3'd3;
    localparam logic [KW-1:0] K_RSR = 3'd4;
    localparam logic [KW-1:0] K_LSR = 3'd5;
    localparam logic [KW-1:0] K_RSC = 3'd6;
    localparam logic [KW-1:0] K_LSC = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   work;
    logic [CW-1:0]  cnt;
    logic           c_q, o_q;
    logic [KW-1:0]  kind;

    logic           accept_c;
    logic [CW-1:0]  cap_cnt_c;
    logic [W-1:0]   step_v_c;
    logic           step_c_c, step_o_c;
    logic           unused_srcb_c;

    // Upper count bits are architecturally ignored.
    assign unused_srcb_c = ^srcB[W-1:CW];

    assign accept_c  = (state == IDLE) && start && opsel[4];
    assign cap_cnt_c = opsel[3] ? srcB[CW-1:0] : CW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nx = (cap_cnt_c == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One bit step of the current work value, carry and overflow.
    always_comb begin
        step_v_c = work;
        step_c_c = c_q;
        step_o_c = o_q;
        case (kind)
            K_RSL: begin step_c_c = work[0];   step_v_c = {1'b0, work[W-1:1]};     end
            K_LSL: begin step_c_c = work[W-1]; step_v_c = {work[W-2:0], 1'b0};     end
            K_RSA: begin step_c_c = work[0];   step_v_c = {work[W-1], work[W-1:1]}; end
            K_LSA: begin
                step_c_c = work[W-1];
                step_v_c = {work[W-2:0], 1'b0};
                // Sticky: sign changes on any step mark overflow.
                step_o_c = o_q | (work[W-1] ^ work[W-2]);
            end
            K_RSR: begin step_c_c = work[0];   step_v_c = {work[0], work[W-1:1]};   end
            K_LSR: begin step_c_c = work[W-1]; step_v_c = {work[W-2:0], work[W-1]}; end
            K_RSC: begin step_c_c = work[0];   step_v_c = {c_q, work[W-1:1]};       end
            K_LSC: begin step_c_c = work[W-1]; step_v_c = {work[W-2:0], c_q};       end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work      <= '0;
            cnt       <= '0;
            c_q       <= 1'b0;
            o_q       <= 1'b0;
            kind      <= '0;
            res       <= '0;
            flag_next <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
        end else begin
            busy  <= (state_nx != IDLE);
            ready <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        work <= srcA;
                        c_q  <= Cflag;
                        cnt  <= cap_cnt_c;
                        kind <= opsel[KW-1:0];
                        // LSA restarts overflow tracking unless there are no steps.
                        o_q  <= ((opsel[KW-1:0] == K_LSA) && (cap_cnt_c != '0)) ? 1'b0 : Oflag;
                        if (cap_cnt_c == '0) begin
                            res       <= srcA;
                            flag_next <= {(srcA == '0), srcA[W-1], Cflag, Oflag};
                        end
                    end
                end
                SHIFT: begin
                    work <= step_v_c;
                    c_q  <= step_c_c;
                    o_q  <= step_o_c;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        res       <= step_v_c;
                        flag_next <= {(step_v_c == '0), step_v_c[W-1], step_c_c, step_o_c};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
